// File: rtl/avalon_s_types_pkg.sv
// Shared types, register addresses and sequencer states for the curl
// Avalon-MM slave front end.
package avalon_s_types_pkg;

  typedef logic [31:0]   bit32;
  typedef logic [1023:0] bit1024;

  localparam logic [5:0] ADDR_CTRL   = 6'h20;
  localparam logic [5:0] ADDR_STATUS = 6'h21;
  localparam logic [5:0] ADDR_RESULT = 6'h22;
  localparam logic [5:0] ADDR_ID     = 6'h23;
  localparam int         BUF_WORDS   = 32;

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

endpackage

// File: rtl/curl_word_buffer.sv
// 32 x 32-bit input block storage with a byte-enabled write port, an
// asynchronous read port and the whole block exposed flat to the core.
module curl_word_buffer
  import avalon_s_types_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  bit32       wr_data,
  input  logic [3:0] wr_be,
  input  logic [4:0] rd_addr,
  output bit32       rd_data,
  output bit1024     flat_data
);

  bit32 words [BUF_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_WORDS; i++) words[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) words[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = words[rd_addr];

  // Word k lands at bits [32k+31:32k] of the flat core bus.
  always_comb begin
    flat_data = '0;
    for (int k = 0; k < BUF_WORDS; k++) flat_data[32*k +: 32] = words[k];
  end

endmodule

// File: rtl/avalon_curl_slave.sv
// Avalon-MM slave front end for the curl core: input buffer, CTRL/STATUS/
// RESULT/ID registers and the start/done handshake sequencer.
module avalon_curl_slave
  import avalon_s_types_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] ID_VALUE = 32'hC0DE_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output bit1024            core_data,
  output logic              core_start,
  input  logic              core_done,
  input  bit32              core_result
);

  state_t state, state_next;
  logic   done_q, err_q, busy;
  bit32   result_q;
  bit32   buf_rd, rd_mux;
  logic   is_buf, wr_fire, rd_fire, start_req, status_w1c, done_evt;

  assign busy            = (state != IDLE);
  assign is_buf          = (avs_address < ADDR_W'(BUF_WORDS));
  assign avs_waitrequest = avs_write && is_buf && busy;
  assign wr_fire         = avs_write && !avs_waitrequest;
  // A write wins over a simultaneous read; the read gets no response.
  assign rd_fire         = avs_read && !avs_write;
  assign start_req       = wr_fire && (avs_address == ADDR_W'(ADDR_CTRL)) && avs_writedata[0];
  assign status_w1c      = wr_fire && (avs_address == ADDR_W'(ADDR_STATUS));
  assign done_evt        = (state == BUSY) && core_done;

  curl_word_buffer u_buffer (
    .clk       (clk),
    .rst_n     (reset_n),
    .wr_en     (wr_fire && is_buf),
    .wr_addr   (avs_address[4:0]),
    .wr_data   (avs_writedata),
    .wr_be     (avs_byteenable),
    .rd_addr   (avs_address[4:0]),
    .rd_data   (buf_rd),
    .flat_data (core_data)
  );

  always_comb begin
    state_next = state;
    core_start = 1'b0;
    unique case (state)
      IDLE:    if (start_req) state_next = START;
      START: begin
        core_start = 1'b1;
        state_next = BUSY;
      end
      BUSY:    if (core_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sticky done/err: a set in the same cycle as a W1C takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (done_evt) begin
        done_q   <= 1'b1;
        result_q <= core_result;
      end else if (start_req && !busy) begin
        done_q <= 1'b0;
      end else if (status_w1c && avs_writedata[1]) begin
        done_q <= 1'b0;
      end
      if (start_req && busy) begin
        err_q <= 1'b1;
      end else if (start_req) begin
        err_q <= 1'b0;
      end else if (status_w1c && avs_writedata[2]) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (is_buf) begin
      rd_mux = buf_rd;
    end else if (avs_address == ADDR_W'(ADDR_STATUS)) begin
      rd_mux = {29'd0, err_q, done_q, busy};
    end else if (avs_address == ADDR_W'(ADDR_RESULT)) begin
      rd_mux = result_q;
    end else if (avs_address == ADDR_W'(ADDR_ID)) begin
      rd_mux = ID_VALUE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_fire;
      if (rd_fire) avs_readdata <= rd_mux;
    end
  end

endmodule
